// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared states and constants for the remote command link
package remote_comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_HI,
    TX_LO,
    WAIT_RESP
  } rc_state_t;

  localparam int         FRAME_BITS   = 10;
  localparam int         NUM_TX_BYTES = 3;
  localparam logic [7:0] RESP_POS_ACK = 8'hA5;

endpackage

// File: rtl/remote_comm_uart_xcvr.sv
// rtl/remote_comm_uart_xcvr.sv - bit-level UART serializer and deserializer
module uart_xcvr
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_line,
  input  logic       rx_line,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(FRAME_BITS - 1);

  logic          tx_q;
  logic          tx_busy_q;
  logic [BW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_shift_q;

  logic [1:0]    rx_sync_q;
  logic          rx_prev_q;
  logic          rx_busy_q;
  logic [BW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_rdy_q;
  logic          rx_ferr_q;
  logic          rx_s;

  // Last clock of the stop bit: a start issued now chains the next frame with no gap.
  assign tx_done = tx_busy_q && (tx_bit_q == LAST_BIT) && (tx_baud_q == BAUD_LAST);
  assign tx_line = tx_q;
  assign rx_s    = rx_sync_q[1];
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;
  assign rx_ferr = rx_ferr_q;

  // Transmit: start bit, eight data bits LSB first, then the stop bit shifted in as a 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (tx_start) begin
      tx_busy_q  <= 1'b1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= {1'b1, tx_data};
      tx_q       <= 1'b0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_q <= '0;
        if (tx_bit_q == LAST_BIT) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_bit_q   <= tx_bit_q + 4'd1;
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
        end
      end else begin
        tx_baud_q <= tx_baud_q + BW'(1);
      end
    end
  end

  // Receive: synchronize, detect falling edge, re-check start at half bit, sample at centres.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_line};
      rx_prev_q <= rx_s;
      rx_rdy_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_s) begin
          rx_busy_q <= 1'b1;
          rx_baud_q <= '0;
          rx_bit_q  <= '0;
        end
      end else if (rx_bit_q == 4'd0) begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_q <= '0;
          if (rx_s) begin
            rx_busy_q <= 1'b0;
          end else begin
            rx_bit_q <= 4'd1;
          end
        end else begin
          rx_baud_q <= rx_baud_q + BW'(1);
        end
      end else begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_q <= '0;
          if (rx_bit_q == LAST_BIT) begin
            rx_busy_q <= 1'b0;
            if (rx_s) begin
              rx_data_q <= rx_shift_q;
              rx_rdy_q  <= 1'b1;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_q <= rx_baud_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - command framing FSM with optional response timeout (REMOTE_COMM_TIMEOUT_EN)
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_CYC  = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        resp_tmo,
  output logic        TX,
  input  logic        RX
);

  rc_state_t   state_q, state_d;
  logic        start_q;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        cmd_sent_q;
  logic [7:0]  resp_q;
  logic        resp_rdy_q;

  logic        accept;
  logic        resp_load;
  logic        tmo_hit;
  logic        tmo_fire;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_ferr;

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_byte),
    .tx_done  (tx_done),
    .tx_line  (TX),
    .rx_line  (RX),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign busy     = busy_q;
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

  // Next-state and byte sequencing; the first byte starts one cycle after acceptance.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    resp_load = 1'b0;
    tmo_fire  = 1'b0;
    tx_start  = 1'b0;
    tx_byte   = cmd_q;
    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          accept  = 1'b1;
          state_d = TX_CMD;
        end
      end
      TX_CMD: begin
        if (start_q) begin
          tx_start = 1'b1;
          tx_byte  = cmd_q;
        end else if (tx_done) begin
          tx_start = 1'b1;
          tx_byte  = data_q[15:8];
          state_d  = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_byte  = data_q[7:0];
          state_d  = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          resp_load = 1'b1;
          state_d   = IDLE;
        end else if (rx_ferr) begin
          // Badly framed byte: drop it and keep listening.
          state_d = WAIT_RESP;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched command, and host-visible status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cmd_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      cmd_sent_q <= 1'b0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= accept;
      cmd_sent_q <= (state_q == TX_LO) && tx_done;
      if (accept) begin
        cmd_q      <= cmd;
        data_q     <= data;
        resp_rdy_q <= 1'b0;
      end
      if (start_q) begin
        busy_q <= 1'b1;
      end
      if (resp_load) begin
        resp_q     <= rx_data;
        resp_rdy_q <= 1'b1;
        busy_q     <= 1'b0;
      end else if (tmo_fire) begin
        busy_q <= 1'b0;
      end
    end
  end

`ifdef REMOTE_COMM_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          resp_tmo_q;

  assign tmo_hit  = (state_q == WAIT_RESP) && (tmo_cnt_q == TW'(TMO_CYC - 1));
  assign resp_tmo = resp_tmo_q;

  // Count cycles spent waiting for a reply and flag a timeout when the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      resp_tmo_q <= 1'b0;
    end else begin
      if (state_q == WAIT_RESP) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
      if (accept) begin
        resp_tmo_q <= 1'b0;
      end else if (tmo_fire) begin
        resp_tmo_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
  assign resp_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - self-checking bench for remote_comm with a line-level reference model
module tb_remote_comm;

  localparam int BD  = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd = 8'h00;
  logic [15:0] data = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        busy;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        resp_tmo;
  logic        TX;
  logic        RX = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_resp = 8'h00;

  remote_comm #(.BAUD_DIV(BD), .TMO_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .data     (data),
    .snd_cmd  (snd_cmd),
    .busy     (busy),
    .cmd_sent (cmd_sent),
    .resp     (resp),
    .resp_rdy (resp_rdy),
    .resp_tmo (resp_tmo),
    .TX       (TX),
    .RX       (RX)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (got running, want finished)");
    $fatal(1);
  end

  // Sends one command and checks the line against the ideal 3-frame waveform.
  // j counts negedges after the sampling edge of snd_cmd; inject_at>0 pulses a stray snd_cmd.
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, input int inject_at);
    logic [7:0] exp_b [3];
    logic [7:0] got_b [3];
    int tx_bad, cs_bad, busy_bad, flag_bad;
    int idx, pos, fr, ph;
    logic e;
    exp_b[0] = c; exp_b[1] = d[15:8]; exp_b[2] = d[7:0];
    for (int i = 0; i < 3; i++) got_b[i] = 8'h00;
    tx_bad = 0; cs_bad = 0; busy_bad = 0; flag_bad = 0;
    @(negedge clk);
    cmd = c; data = d; snd_cmd = 1'b1;
    for (int j = 0; j <= 482; j++) begin
      @(negedge clk);
      e = 1'b1;
      if (j >= 1 && j <= 30 * BD) begin
        idx = (j - 1) / BD;
        ph  = (j - 1) % BD;
        fr  = idx / 10;
        pos = idx % 10;
        if (pos == 0) e = 1'b0;
        else if (pos == 9) e = 1'b1;
        else e = exp_b[fr][pos-1];
        if (ph == BD / 2 && pos >= 1 && pos <= 8) got_b[fr][pos-1] = TX;
      end
      if (TX !== e) tx_bad++;
      if (cmd_sent !== (j == 30 * BD + 1)) cs_bad++;
      if (busy !== (j >= 1)) busy_bad++;
      if (resp_rdy !== 1'b0 || resp_tmo !== 1'b0) flag_bad++;
      if (inject_at != 0 && j == inject_at) begin
        cmd = 8'hFF; data = 16'($urandom); snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
        if (j == 0) begin cmd = 8'($urandom); data = 16'($urandom); end
      end
    end
    checks++;
    if (tx_bad !== 0) begin errors++; $display("FAIL tx_line: %0d bad cycles, want 0", tx_bad); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin
        errors++; $display("FAIL tx_byte%0d: got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
    checks++;
    if (cs_bad !== 0) begin errors++; $display("FAIL cmd_sent_timing: %0d bad cycles, want 0", cs_bad); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL busy_tx: %0d bad cycles, want 0", busy_bad); end
    checks++;
    if (flag_bad !== 0) begin errors++; $display("FAIL flags_cleared: %0d bad cycles, want 0", flag_bad); end
  endtask

  // Drives one response frame on RX. mode 0: accepted; 1: dropped while waiting; 2: dropped in idle.
  task automatic send_resp(input logic [7:0] b, input logic stop, input int mode);
    int bp, rise;
    logic bz;
    rise = -1; bz = 1'b1;
    for (int k = 0; k < 12 * BD; k++) begin
      bp = k / BD;
      if (bp == 0) RX = 1'b0;
      else if (bp <= 8) RX = b[bp-1];
      else if (bp == 9) RX = stop;
      else RX = 1'b1;
      @(negedge clk);
      if (rise < 0 && resp_rdy === 1'b1) begin rise = k + 1; bz = busy; end
    end
    RX = 1'b1;
    if (mode == 0) begin
      exp_resp = b;
      checks++;
      if (resp !== b) begin errors++; $display("FAIL resp_value: got %h want %h", resp, b); end
      checks++;
      if (rise < 9 * BD + 6 || rise > 9 * BD + 18) begin
        errors++; $display("FAIL resp_rdy_time: got %0d want %0d..%0d", rise, 9 * BD + 6, 9 * BD + 18);
      end
      checks++;
      if (bz !== 1'b0) begin errors++; $display("FAIL busy_with_rdy: got %b want 0", bz); end
    end else begin
      checks++;
      if (resp !== exp_resp) begin errors++; $display("FAIL resp_kept: got %h want %h", resp, exp_resp); end
      checks++;
      if (resp_rdy !== (mode == 2)) begin
        errors++; $display("FAIL resp_rdy_drop: got %b want %b", resp_rdy, (mode == 2));
      end
      checks++;
      if (busy !== (mode == 1)) begin errors++; $display("FAIL busy_drop: got %b want %b", busy, (mode == 1)); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", TX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL rst_cmd_sent: got %b want 0", cmd_sent); end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL rst_resp: got %h want 00", resp); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_resp_rdy: got %b want 0", resp_rdy); end
    checks++; if (resp_tmo !== 1'b0) begin errors++; $display("FAIL rst_resp_tmo: got %b want 0", resp_tmo); end
    rst = 1'b0;
    exp_resp = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    send_cmd(8'h02, 16'h1234, 0);
    send_resp(remote_comm_pkg::RESP_POS_ACK, 1'b1, 0);
  endtask

  task automatic test_ignore_busy();
    send_cmd(8'h02, 16'h1234, 200);
    send_resp(remote_comm_pkg::RESP_POS_ACK, 1'b1, 0);
  endtask

  task automatic test_ferr_glitch();
    send_cmd(8'($urandom), 16'($urandom), 0);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    checks++;
    if (resp_rdy !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL glitch: got rdy=%b busy=%b want rdy=0 busy=1", resp_rdy, busy);
    end
    send_resp(8'($urandom), 1'b0, 1);
    send_resp(8'h5A, 1'b1, 0);
  endtask

  task automatic test_outside_wait();
    send_resp(8'($urandom), 1'b1, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd = 8'h02; data = 16'h0000; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (197) @(negedge clk);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL pre_rst_tx: got %b want 0", TX); end
    rst = 1'b1;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b want 1", TX); end
    checks++;
    if (busy !== 1'b0 || cmd_sent !== 1'b0 || resp_rdy !== 1'b0 || resp_tmo !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_flags: got busy=%b sent=%b rdy=%b tmo=%b want all 0", busy, cmd_sent, resp_rdy, resp_tmo);
    end
    checks++; if (resp !== 8'h00) begin errors++; $display("FAIL mid_rst_resp: got %h want 00", resp); end
    exp_resp = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(8'($urandom), 16'($urandom), 0);
    send_resp(8'($urandom), 1'b1, 0);
  endtask

  task automatic test_timeout();
    int rise;
    logic bz;
    rise = -1; bz = 1'b1;
    send_cmd(8'($urandom), 16'($urandom), 0);
`ifdef REMOTE_COMM_TIMEOUT_EN
    for (int j = 483; j < 1600; j++) begin
      @(negedge clk);
      if (rise < 0 && resp_tmo === 1'b1) begin rise = j; bz = busy; end
    end
    checks++;
    if (rise !== 30 * BD + 1 + TMO) begin
      errors++; $display("FAIL tmo_time: got %0d want %0d", rise, 30 * BD + 1 + TMO);
    end
    checks++; if (bz !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", bz); end
    checks++; if (resp !== exp_resp) begin errors++; $display("FAIL tmo_resp: got %h want %h", resp, exp_resp); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy: got %b want 0", resp_rdy); end
`else
    for (int j = 483; j < 1700; j++) begin
      @(negedge clk);
      if (rise < 0 && (resp_tmo !== 1'b0 || busy !== 1'b1)) rise = j;
    end
    checks++;
    if (rise !== -1) begin errors++; $display("FAIL wait_forever: left waiting at %0d, want never", rise); end
    send_resp(8'($urandom), 1'b1, 0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_cmd(8'($urandom), 16'($urandom), 0);
      repeat ($urandom_range(0, 100)) @(negedge clk);
      send_resp(8'($urandom), 1'b1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_ferr_glitch();
    test_outside_wait();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
